service_packet_scheduler: RTL and testbench
===========================================

SERVICE_PACKET_SCHEDULER -- requirements
Module: service_packet_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: idle cycles allowed in STREAM before abort.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  2  req[i]=1: requester i holds a complete reply packet.
REQ-005 cmd0, cmd1  in  8  command code of requester i packet.
REQ-006 addr0, addr1  in  8  destination address of requester i packet.
REQ-007 len0, len1  in  8  data word count of requester i packet, 0..255.
REQ-008 src_data0, src_data1  in  16  head data word of requester i FIFO.
REQ-009 src_rdy  in  2  src_rdy[i]=1: src_data_i valid.
REQ-010 src_pop  out  2  one-hot pop strobe to the granted requester.
REQ-011 grant  out  2  one-hot ownership of the encoder; 0 when free.
REQ-012 enc_start  out  1  one-cycle pulse starting the encoder packet.
REQ-013 enc_cmd, enc_addr, enc_num  out  8 each  latched header fields to the encoder.
REQ-014 enc_data  out  16  data word to the encoder; enc_data_vld out 1; enc_data_rdy in 1.
REQ-015 enc_busy  in  1  encoder is emitting a packet.
REQ-016 enc_abort  out  1  one-cycle pulse: encoder discards current packet.
REQ-017 pkt_done  out  2  one-cycle one-hot pulse: requester i packet fully handed off.
REQ-018 err_timeout  out  1  one-cycle pulse on STREAM timeout abort.

Function
REQ-019 States SHALL be IDLE, START, STREAM, WAIT_DONE.
REQ-020 IDLE: if req!=0, select requester by round-robin, latch cmd/addr/len of the selected one, set grant, go START next cycle.
REQ-021 Round-robin: single req -> that one; both -> the one not granted last; last-granted pointer reset to 1, so requester 0 wins first simultaneous request.
REQ-022 START: while enc_busy=1 hold; when enc_busy=0 pulse enc_start for exactly one cycle with enc_cmd/enc_addr/enc_num valid that cycle, then go STREAM if len!=0, else WAIT_DONE.
REQ-023 enc_cmd/enc_addr/enc_num SHALL stay stable from START until return to IDLE.
REQ-024 STREAM: enc_data = src_data of granted requester (combinational); enc_data_vld = src_rdy[granted]; transfer when enc_data_vld and enc_data_rdy both 1.
REQ-025 src_pop[granted] = 1 exactly in transfer cycles; src_pop of non-granted requester always 0; src_pop=0 outside STREAM.
REQ-026 8-bit word counter loaded with len in START, decremented per transfer; transfer at count 1 -> WAIT_DONE next cycle; never more than len pops.
REQ-027 WAIT_DONE: when enc_busy=0 pulse pkt_done[granted], clear grant, update last-granted pointer, go IDLE; earliest next grant one cycle later.
REQ-028 Timeout counter cleared on entering STREAM and on each transfer, incremented otherwise; at TIMEOUT_CYCLES: pulse enc_abort and err_timeout, no pkt_done, clear grant, update pointer, go IDLE.
REQ-029 Changes of req, cmd, addr or len after latching SHALL be ignored until IDLE.
REQ-030 enc_start, enc_abort, pkt_done, err_timeout SHALL never assert in the same cycle as one another.

Reset
REQ-031 rst=1 at any edge, including mid-packet, SHALL force IDLE, grant=0, src_pop=0, enc_start=0, enc_abort=0, pkt_done=0, err_timeout=0, enc_data_vld=0, enc_cmd/enc_addr/enc_num=0, counters=0, pointer=1; no enc_abort is issued for the interrupted packet.

Verification
REQ-032 req=01, cmd0=0xA2, addr0=0x02, len0=3, src_rdy always 1, enc_data_rdy=1 -> grant=01 one cycle later, one enc_start with 0xA2/0x02/3, exactly 3 src_pop[0], pkt_done=01 once after enc_busy falls.
REQ-033 req=11 held from reset, each len=2 -> order requester 0, 1, 0, 1; no overlap of grants; 2 pops per packet.
REQ-034 len1=0 with req=10 -> enc_start with enc_num=0, no src_pop, pkt_done=10 after enc_busy=0.
REQ-035 len0=4, src_rdy[0] drops after 2 transfers, TIMEOUT_CYCLES=16 -> enc_abort and err_timeout pulse 16 cycles after last transfer, grant=00, no pkt_done.
REQ-036 enc_busy=1 when START entered, released after 10 cycles -> enc_start asserted only in the cycle enc_busy is sampled 0; enc_data_rdy toggled 1/0 -> pops only on vld&rdy.
REQ-037 rst asserted mid-STREAM after 1 of 5 words -> all outputs reset values next cycle; following req=01 starts a fresh packet with full len0.

Source files
------------

// File: rtl/service_packet_scheduler.sv
// Two-requester packet scheduler in front of a packet encoder.
// A round-robin arbiter picks a requester holding a complete reply packet,
// latches its header, starts the encoder, streams the data words from the
// requester FIFO and reports completion, or aborts when the stream stalls
// for TIMEOUT_CYCLES cycles.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | encoder free; arbitrate among pending requests
// START     | header latched; wait for encoder idle, then pulse enc_start
// STREAM    | move len data words from the granted FIFO to the encoder
// WAIT_DONE | all words handed off; wait for encoder idle, pulse pkt_done
module service_packet_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  cmd1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [7:0]  len0,
  input  logic [7:0]  len1,
  input  logic [15:0] src_data0,
  input  logic [15:0] src_data1,
  input  logic [1:0]  src_rdy,
  output logic [1:0]  src_pop,
  output logic [1:0]  grant,
  output logic        enc_start,
  output logic [7:0]  enc_cmd,
  output logic [7:0]  enc_addr,
  output logic [7:0]  enc_num,
  output logic [15:0] enc_data,
  output logic        enc_data_vld,
  input  logic        enc_data_rdy,
  input  logic        enc_busy,
  output logic        enc_abort,
  output logic [1:0]  pkt_done,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_STREAM    = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Wide enough to hold TIMEOUT_CYCLES-1, the last value before abort.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    grant_q;
  logic          last_q;      // index of the requester granted most recently
  logic          sel_idx;
  logic          gidx;
  logic          xfer;
  logic [7:0]    cmd_q, addr_q, num_q;
  logic [7:0]    cnt_q;
  logic [TW-1:0] to_q;

  assign gidx     = grant_q[1];
  assign grant    = grant_q;
  assign enc_cmd  = cmd_q;
  assign enc_addr = addr_q;
  assign enc_num  = num_q;

  // Round-robin pick: a lone requester wins; on a tie the one not served last.
  always_comb begin
    sel_idx = 1'b0;
    if (req == 2'b10)      sel_idx = 1'b1;
    else if (req == 2'b11) sel_idx = ~last_q;
  end

  // Next-state and strobe generation.
  always_comb begin
    state_d      = state_q;
    enc_start    = 1'b0;
    enc_abort    = 1'b0;
    err_timeout  = 1'b0;
    pkt_done     = 2'b00;
    src_pop      = 2'b00;
    enc_data     = 16'h0000;
    enc_data_vld = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) state_d = S_START;
      end
      S_START: begin
        if (!enc_busy) begin
          enc_start = 1'b1;
          state_d   = (num_q != 8'd0) ? S_STREAM : S_WAIT_DONE;
        end
      end
      S_STREAM: begin
        enc_data     = gidx ? src_data1 : src_data0;
        enc_data_vld = src_rdy[gidx];
        xfer         = enc_data_vld & enc_data_rdy;
        src_pop      = xfer ? grant_q : 2'b00;
        if (xfer) begin
          if (cnt_q == 8'd1) state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          enc_abort   = 1'b1;
          err_timeout = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!enc_busy) begin
          pkt_done = grant_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Grant, header latch, word counter and stall timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cmd_q   <= 8'h00;
      addr_q  <= 8'h00;
      num_q   <= 8'h00;
      cnt_q   <= 8'h00;
      to_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            grant_q <= sel_idx ? 2'b10 : 2'b01;
            cmd_q   <= sel_idx ? cmd1  : cmd0;
            addr_q  <= sel_idx ? addr1 : addr0;
            num_q   <= sel_idx ? len1  : len0;
          end
        end
        S_START: begin
          if (enc_start) begin
            cnt_q <= num_q;
            to_q  <= '0;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            cnt_q <= cnt_q - 8'd1;
            to_q  <= '0;
          end else if (enc_abort) begin
            grant_q <= 2'b00;
            last_q  <= gidx;
            cnt_q   <= 8'h00;
            to_q    <= '0;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!enc_busy) begin
            grant_q <= 2'b00;
            last_q  <= gidx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_service_packet_scheduler.sv
// Scoreboard bench: stimulus pushes expected encoder-side events, a monitor
// pops and compares them as the scheduler emits them. A small encoder/FIFO
// model drives enc_busy and the source data words.
module tb_service_packet_scheduler;

  localparam int TO = 16;
  localparam int K_START = 0, K_POP = 1, K_DONE = 2, K_ABORT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  cmd0, cmd1, addr0, addr1, len0, len1;
  logic [15:0] src_data0, src_data1;
  logic [1:0]  src_rdy;
  logic [1:0]  src_pop;
  logic [1:0]  grant;
  logic        enc_start;
  logic [7:0]  enc_cmd, enc_addr, enc_num;
  logic [15:0] enc_data;
  logic        enc_data_vld;
  logic        enc_data_rdy;
  logic        enc_busy;
  logic        enc_abort;
  logic [1:0]  pkt_done;
  logic        err_timeout;
  logic        hold_busy;

  typedef struct {
    int         kind;
    logic [1:0] g;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int e0 = 0;
  int e1 = 0;

  service_packet_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .cmd0(cmd0), .cmd1(cmd1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1),
    .src_data0(src_data0), .src_data1(src_data1), .src_rdy(src_rdy),
    .src_pop(src_pop), .grant(grant), .enc_start(enc_start),
    .enc_cmd(enc_cmd), .enc_addr(enc_addr), .enc_num(enc_num),
    .enc_data(enc_data), .enc_data_vld(enc_data_vld), .enc_data_rdy(enc_data_rdy),
    .enc_busy(enc_busy), .enc_abort(enc_abort), .pkt_done(pkt_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input logic [1:0] g, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] c);
    exp_t e;
    e.kind = kind; e.g = g; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_pops(input logic [1:0] g, input int n);
    for (int k = 0; k < n; k++) begin
      if (g == 2'b01) begin push(K_POP, g, 16'h1000 + 16'(e0), 0, 0); e0++; end
      else            begin push(K_POP, g, 16'h2000 + 16'(e1), 0, 0); e1++; end
    end
  endtask

  task automatic take(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.g = 0; e.a = 0; e.b = 0; e.c = 0;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event kind=%0d actual=present expected=none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: compares every emitted event against the scoreboard head.
  initial begin
    int   cyc;
    int   last_pop;
    int   s;
    bit   chk_clr;
    bit   ok;
    exp_t e;
    cyc = 0; last_pop = 0; chk_clr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b0) begin
        chk_clr = 0;
      end else begin
        if (chk_clr) begin
          chk("grant_cleared_after_abort", grant, 2'b00);
          chk_clr = 0;
        end
        if (enc_start || enc_abort || err_timeout || (|pkt_done)) begin
          s = int'(enc_start) + int'(enc_abort) + int'(|pkt_done);
          chk("pulse_exclusive", s, 1);
          chk("timeout_with_abort", err_timeout, enc_abort);
        end
        if (enc_start) begin
          take(K_START, e, ok);
          if (ok) begin
            chk("start_grant", grant, e.g);
            chk("start_cmd", enc_cmd, e.a);
            chk("start_addr", enc_addr, e.b);
            chk("start_num", enc_num, e.c);
            chk("start_busy_low", enc_busy, 1'b0);
          end
        end
        if (|src_pop) begin
          take(K_POP, e, ok);
          if (ok) begin
            chk("pop_onehot", src_pop, e.g);
            chk("pop_data", enc_data, e.a);
            chk("pop_handshake", {enc_data_vld, enc_data_rdy}, 2'b11);
          end
          last_pop = cyc;
        end
        if (|pkt_done) begin
          take(K_DONE, e, ok);
          if (ok) begin
            chk("done_onehot", pkt_done, e.g);
            chk("done_busy_low", enc_busy, 1'b0);
          end
        end
        if (enc_abort) begin
          take(K_ABORT, e, ok);
          if (ok) begin
            chk("abort_grant", grant, e.g);
            chk("abort_delay", cyc - last_pop, e.a);
          end
          chk_clr = 1;
        end
      end
    end
  end

  // Encoder and source FIFO model: busy from enc_start until a short tail
  // after the last word (or abort); FIFO heads advance on each pop.
  initial begin
    bit         s_start, s_abort, s_rst, m;
    logic [1:0] s_pop;
    logic [7:0] s_num;
    int         rem, tail, w0, w1;
    m = 0; rem = 0; tail = 0; w0 = 0; w1 = 0;
    enc_busy = 1'b0;
    src_data0 = 16'h1000;
    src_data1 = 16'h2000;
    forever begin
      @(negedge clk); #2;
      s_start = enc_start; s_abort = enc_abort; s_pop = src_pop;
      s_num = enc_num; s_rst = rst;
      @(posedge clk); #1;
      if (s_rst) begin
        m = 0; rem = 0; tail = 0;
      end else begin
        if (s_start) begin
          m = 1; rem = int'(s_num); tail = 0;
        end else if (m) begin
          if (s_abort) m = 0;
          else if (rem == 0) begin
            tail++;
            if (tail >= 2) m = 0;
          end
        end
        if (s_pop[0]) w0++;
        if (s_pop[1]) w1++;
        if ((|s_pop) && rem > 0) rem--;
      end
      enc_busy = m | hold_busy;
      src_data0 = 16'h1000 + 16'(w0);
      src_data1 = 16'h2000 + 16'(w1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic wait_pulses(input int which, input int n, input int budget, input string name);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (which == 0 ? enc_start : src_pop[0]) seen++;
    end
    if (seen < n) begin
      checks++; failures++;
      $display("FAIL %s wait_expired seen=%0d expected=%0d", name, seen, n);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && grant == 2'b00) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s wait_expired pending=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_src_pop"}, src_pop, 2'b00);
    chk({tag, "_strobes"}, {enc_start, enc_abort, pkt_done, err_timeout}, 5'b0);
    chk({tag, "_data_vld"}, enc_data_vld, 1'b0);
    chk({tag, "_header"}, {enc_cmd, enc_addr, enc_num}, 24'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    bit stop;
    rst = 1'b1; req = 2'b00; hold_busy = 1'b0;
    cmd0 = 0; cmd1 = 0; addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
    src_rdy = 2'b11; enc_data_rdy = 1'b1;
    tick(4);
    rst = 1'b0;
    check_reset_state("reset");
    @(posedge clk); #1;

    // Single packet, header changes after latching are ignored.
    cmd0 = 8'hA2; addr0 = 8'h02; len0 = 8'd3;
    push(K_START, 2'b01, 16'hA2, 16'h02, 16'd3);
    push_pops(2'b01, 3);
    push(K_DONE, 2'b01, 0, 0, 0);
    req = 2'b01;
    tick(1);
    req = 2'b00; cmd0 = 8'h55; addr0 = 8'h99; len0 = 8'd7;
    @(negedge clk);
    chk("grant_one_cycle_later", grant, 2'b01);
    wait_idle("single_packet", 200);

    // Both requesting from reset: strict alternation starting with 0.
    do_reset();
    cmd0 = 8'h11; addr0 = 8'h10; len0 = 8'd2;
    cmd1 = 8'h22; addr1 = 8'h20; len1 = 8'd2;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push(K_START, 2'b01, 16'h11, 16'h10, 16'd2); push_pops(2'b01, 2); push(K_DONE, 2'b01, 0, 0, 0);
      end else begin
        push(K_START, 2'b10, 16'h22, 16'h20, 16'd2); push_pops(2'b10, 2); push(K_DONE, 2'b10, 0, 0, 0);
      end
    end
    req = 2'b11;
    wait_pulses(0, 4, 400, "rr_starts");
    @(posedge clk); #1;
    req = 2'b00;
    wait_idle("round_robin", 200);

    // Zero-length packet from requester 1.
    cmd1 = 8'h33; addr1 = 8'h30; len1 = 8'd0;
    push(K_START, 2'b10, 16'h33, 16'h30, 16'd0);
    push(K_DONE, 2'b10, 0, 0, 0);
    req = 2'b10;
    tick(1);
    req = 2'b00;
    wait_idle("zero_len", 100);

    // Source stalls after two of four words: abort after TO idle cycles.
    cmd0 = 8'h44; addr0 = 8'h40; len0 = 8'd4;
    push(K_START, 2'b01, 16'h44, 16'h40, 16'd4);
    push_pops(2'b01, 2);
    push(K_ABORT, 2'b01, 16'(TO), 0, 0);
    req = 2'b01;
    tick(1);
    req = 2'b00;
    wait_pulses(1, 2, 100, "stall_pops");
    @(posedge clk); #1;
    src_rdy = 2'b10;
    wait_idle("timeout", 200);
    src_rdy = 2'b11;
    tick(2);

    // Encoder busy at START for 10 cycles; data ready toggling.
    hold_busy = 1'b1;
    tick(2);
    cmd0 = 8'h66; addr0 = 8'h60; len0 = 8'd3;
    push(K_START, 2'b01, 16'h66, 16'h60, 16'd3);
    push_pops(2'b01, 3);
    push(K_DONE, 2'b01, 0, 0, 0);
    req = 2'b01;
    tick(1);
    req = 2'b00;
    stop = 0;
    fork
      begin
        for (int i = 0; i < 300 && !stop; i++) begin
          enc_data_rdy = ~enc_data_rdy;
          tick(1);
        end
      end
      begin
        tick(9);
        hold_busy = 1'b0;
        wait_idle("busy_hold_toggle", 200);
        stop = 1;
      end
    join
    enc_data_rdy = 1'b1;
    tick(2);

    // Reset mid-stream after one of five words, then a fresh packet.
    cmd0 = 8'h77; addr0 = 8'h70; len0 = 8'd5;
    push(K_START, 2'b01, 16'h77, 16'h70, 16'd5);
    push_pops(2'b01, 1);
    req = 2'b01;
    tick(1);
    req = 2'b00;
    wait_pulses(1, 1, 50, "pre_reset_pop");
    @(posedge clk); #1;
    rst = 1'b1; src_rdy = 2'b00;
    tick(1);
    rst = 1'b0;
    check_reset_state("mid_reset");
    chk("mid_reset_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    src_rdy = 2'b11;
    push(K_START, 2'b01, 16'h77, 16'h70, 16'd5);
    push_pops(2'b01, 5);
    push(K_DONE, 2'b01, 0, 0, 0);
    req = 2'b01;
    tick(1);
    req = 2'b00;
    wait_idle("after_reset", 200);

    tick(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
